dekatron_step_counter: RTL and testbench
========================================

Name: dekatron_step_counter

Overview:
Parametrised multi-digit decimal (BCD) dekatron counter that executes multi-step INC/DEC commands, plus SET and CLEAR.
Each unit step is held for PULSE_CYCLES clocks to emulate glow-transfer time. Overflow handling is selectable: wrap or saturate. The top limit is either all-nines or TOP_VALUE.
Used as the next-generation IP/AP/data counter where one request moves the counter by N positions.

Parameters:
D_NUM, 3, number of decimal digits
WIDTH, D_NUM*DEKATRON_WIDTH, counter width (4 bits per digit)
STEP_W, 8, width of Steps input
PULSE_CYCLES, 10, clocks per unit step (>=1)
LIMIT_MODE, 0, 0: limit = all digits 9; 1: limit = TOP_VALUE
OVF_MODE, 0, 0: wrap; 1: saturate
TOP_VALUE, {4'd2,4'd5,4'd5}, BCD upper limit when LIMIT_MODE=1

Ports:
Clk  in  1  clock
Rst_n  in  1  reset, asynchronous, active-low
Request  in  1  command valid, sampled only when Ready=1
Op  in  2  00 INC, 01 DEC, 10 SET, 11 CLEAR
Steps  in  STEP_W  unit steps for INC/DEC
In  in  WIDTH  BCD load value for SET
Ready  out  1  idle, command may be accepted
Done  out  1  one-cycle pulse on command completion
Out  out  WIDTH  BCD counter value
Zero  out  1  Out == 0
AtTop  out  1  Out == limit
Wrap  out  1  one-cycle pulse coincident with a wrapping step
Sat  out  1  sticky: last command saturated
Invalid  out  1  sticky: last SET rejected

Behaviour:
- Reset (async): state IDLE; Out=0; Ready=1; Done=Wrap=Sat=Invalid=0; step and wait counters 0.
- Ready = (state==IDLE), registered. Accept = Ready & Request, taken at the end of the accept cycle a.
- On accept:
  - Op, Steps and In are latched.
  - Sat and Invalid are cleared.
  - Next state: SET, CLEAR, or Steps==0 -> LOAD; otherwise -> STEP.
- Request while Ready=0 is ignored, not queued. Request held high re-accepts on the first cycle Ready returns.
- States: IDLE, LOAD, STEP, WAIT.
- LOAD (1 cycle), at its end:
  - CLEAR: Out <= 0.
  - SET: Out <= In if every digit <=9 and In <= limit. Otherwise Out is unchanged and Invalid <= 1.
  - Steps==0: Out is unchanged.
  - Done <= 1; state -> IDLE. Done and Ready are both visible in cycle a+2.
- STEP (1 cycle), at its end:
  - Out <= Out±1 with BCD digit ripple in the same cycle (9->0 carries; 0->9 borrows).
  - remaining <= remaining-1.
  - If PULSE_CYCLES>1: state -> WAIT with wait count PULSE_CYCLES-1.
  - Else: state -> STEP if remaining>0, otherwise IDLE with Done.
- WAIT: counts down. On expiry, state -> STEP if steps remain, otherwise IDLE with Done.
- INC/DEC with n>0 steps, no saturation: Done is high in cycle a+1+n*PULSE_CYCLES. Out changes at the ends of cycles a+1+k*PULSE_CYCLES, k=0..n-1.
- Boundary, wrap mode (OVF_MODE=0):
  - INC at limit -> 0; DEC at 0 -> limit.
  - Wrap pulses for 1 cycle, aligned with the Out update.
  - Remaining steps continue.
- Boundary, saturate mode (OVF_MODE=1):
  - A step that would cross the limit leaves Out unchanged and sets Sat <= 1.
  - The remaining steps are discarded. State -> IDLE with Done at the end of that STEP cycle, skipping WAIT.
- Zero and AtTop are combinational from the Out register.
- Out never holds a non-BCD digit or a value above the limit.
- Reset mid-command aborts immediately to reset values. No Done pulse is produced.

Decomposition:
- parameters.sv: DEKATRON_WIDTH (existing).
- New dekatron_pkg:
  - op enum (OP_INC, OP_DEC, OP_SET, OP_CLEAR);
  - state enum (IDLE, LOAD, STEP, WAIT);
  - OVF_WRAP and OVF_SAT constants.
- One natural sub-module: bcd_unit_step, combinational. Inputs: value, dir, limit. Outputs: next value, wrapped flag, crossed flag. Generate-loop ripple over D_NUM digits.

Test Plan:
- Reset, then INC Steps=1 with PULSE_CYCLES=10, accept in cycle a -> Out 000->001 at end of a+1; Done in a+11; Ready low a+1..a+10.
- SET In=0x199, then INC Steps=3 -> Out 200, 201, 202 at 10-cycle spacing (carry across two digits); Done once.
- LIMIT_MODE=1, TOP=255, wrap mode: SET 254, INC 3 -> Out 255, 000 (Wrap pulse), 001. Then DEC 2 from 001 -> 000, 255 (Wrap); AtTop=1.
- Saturate mode: SET 253, INC 5 -> Out 254, 255, then Sat=1 and Done one cycle after the rejected STEP; Out stays 255.
- SET In=0x2A0 (non-BCD) and SET In=0x300 (>TOP) -> Invalid=1, Out unchanged, Done at a+2. CLEAR -> Out=000, Zero=1, Invalid cleared.
- Assert Rst_n low mid-WAIT of INC 5 -> Out=0, Ready=1, no Done. Request pulsed while busy is ignored; Request held high re-accepts in the first Ready cycle.

Source files
------------

// File: rtl/dekatron_pkg.sv
// Shared types and constants for the dekatron step counter family.
package dekatron_pkg;

  localparam int DEKATRON_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_INC   = 2'b00,
    OP_DEC   = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] STEP = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  localparam int OVF_WRAP = 0;
  localparam int OVF_SAT  = 1;

endpackage

// File: rtl/dekatron_step_counter_bcd_unit_step.sv
// Combinational +/-1 on a multi-digit BCD value with digit ripple and
// wrap-around at 0 / limit.
module bcd_unit_step
  import dekatron_pkg::*;
#(
  parameter int D_NUM = 3,
  parameter int WIDTH = D_NUM * DEKATRON_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,      // 0 = up, 1 = down
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] nxt,
  output logic             wrapped,
  output logic             crossed
);

  logic [D_NUM:0]   carry;
  logic [WIDTH-1:0] ripple;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < D_NUM; i++) begin : g_digit
    logic [DEKATRON_WIDTH-1:0] d;
    logic                      edge_d;
    assign d      = value[i*DEKATRON_WIDTH +: DEKATRON_WIDTH];
    assign edge_d = dir ? (d == 4'd0) : (d == 4'd9);
    assign carry[i+1] = carry[i] & edge_d;
    assign ripple[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] =
      !carry[i] ? d :
      edge_d    ? (dir ? 4'd9 : 4'd0) :
      dir       ? d - 4'd1 : d + 4'd1;
  end

  // Limit may be below all-nines, so the crossing test is on the whole value.
  assign crossed = dir ? (value == '0) : (value == limit);
  assign wrapped = crossed;
  assign nxt     = crossed ? (dir ? limit : '0) : ripple;

endmodule

// File: rtl/dekatron_step_counter.sv
// Multi-digit BCD dekatron counter: multi-step INC/DEC with per-step dwell,
// SET with validation, CLEAR, and wrap or saturate at the limit.
module dekatron_step_counter
  import dekatron_pkg::*;
#(
  parameter int              D_NUM        = 3,
  parameter int              WIDTH        = D_NUM * DEKATRON_WIDTH,
  parameter int              STEP_W       = 8,
  parameter int              PULSE_CYCLES = 10,
  parameter int              LIMIT_MODE   = 0,
  parameter int              OVF_MODE     = OVF_WRAP,
  parameter logic [WIDTH-1:0] TOP_VALUE   = WIDTH'(12'h255)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Request,
  input  logic [1:0]        Op,
  input  logic [STEP_W-1:0] Steps,
  input  logic [WIDTH-1:0]  In,
  output logic              Ready,
  output logic              Done,
  output logic [WIDTH-1:0]  Out,
  output logic              Zero,
  output logic              AtTop,
  output logic              Wrap,
  output logic              Sat,
  output logic              Invalid
);

  localparam int WAIT_W = $clog2(PULSE_CYCLES + 1);

  logic [1:0]        state;
  op_e               op_q;
  logic [WIDTH-1:0]  in_q;
  logic [STEP_W-1:0] remaining;
  logic [WAIT_W-1:0] wait_cnt;

  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  step_nxt;
  logic              step_wrap;
  logic              step_cross;
  logic [D_NUM-1:0]  dig_ok;
  logic              set_ok;

  assign limit = (LIMIT_MODE != 0) ? TOP_VALUE : {D_NUM{4'h9}};

  for (genvar i = 0; i < D_NUM; i++) begin : g_chk
    assign dig_ok[i] = in_q[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] <= 4'd9;
  end
  // Binary compare is valid once every digit is known to be BCD.
  assign set_ok = (&dig_ok) && (in_q <= limit);

  bcd_unit_step #(.D_NUM(D_NUM), .WIDTH(WIDTH)) u_step (
    .value   (Out),
    .dir     (op_q == OP_DEC),
    .limit   (limit),
    .nxt     (step_nxt),
    .wrapped (step_wrap),
    .crossed (step_cross)
  );

  assign Zero  = (Out == '0);
  assign AtTop = (Out == limit);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      Ready     <= 1'b1;
      Done      <= 1'b0;
      Wrap      <= 1'b0;
      Sat       <= 1'b0;
      Invalid   <= 1'b0;
      Out       <= '0;
      op_q      <= OP_INC;
      in_q      <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
    end else begin
      Done <= 1'b0;
      Wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (Ready && Request) begin
            op_q      <= op_e'(Op);
            in_q      <= In;
            remaining <= Steps;
            Sat       <= 1'b0;
            Invalid   <= 1'b0;
            Ready     <= 1'b0;
            if (Op[1] || Steps == '0) state <= LOAD;
            else                      state <= STEP;
          end
        end
        LOAD: begin
          if (op_q == OP_CLEAR) Out <= '0;
          else if (op_q == OP_SET) begin
            if (set_ok) Out <= in_q;
            else        Invalid <= 1'b1;
          end
          Done  <= 1'b1;
          Ready <= 1'b1;
          state <= IDLE;
        end
        STEP: begin
          if (step_cross && OVF_MODE == OVF_SAT) begin
            // Rejected step drops the rest of the command without dwelling.
            Sat       <= 1'b1;
            remaining <= '0;
            Done      <= 1'b1;
            Ready     <= 1'b1;
            state     <= IDLE;
          end else begin
            Out       <= step_nxt;
            Wrap      <= step_wrap;
            remaining <= remaining - STEP_W'(1);
            if (PULSE_CYCLES > 1) begin
              wait_cnt <= WAIT_W'(PULSE_CYCLES - 1);
              state    <= WAIT;
            end else if (remaining > STEP_W'(1)) begin
              state <= STEP;
            end else begin
              Done  <= 1'b1;
              Ready <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: begin
          if (wait_cnt <= WAIT_W'(1)) begin
            if (remaining != '0) state <= STEP;
            else begin
              Done  <= 1'b1;
              Ready <= 1'b1;
              state <= IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dekatron_step_counter.sv
// Directed bench: default-limit wrap (P=10), TOP=255 wrap (P=3), TOP=255 saturate (P=1).
module tb_dekatron_step_counter;
  import dekatron_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [1:0]  op;
  logic [7:0]  steps;
  logic [11:0] din;
  logic        rdy[3], dn[3], zero[3], attop[3], wrp[3], sat[3], inv[3];
  logic [11:0] out[3];

  logic [11:0] out_tr[0:40];
  logic        done_tr[0:40], rdy_tr[0:40], wrap_tr[0:40], sat_tr[0:40];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dekatron_step_counter #(.PULSE_CYCLES(10)) u_dec (
    .Clk(clk), .Rst_n(rst_n), .Request(req[0]), .Op(op), .Steps(steps), .In(din),
    .Ready(rdy[0]), .Done(dn[0]), .Out(out[0]), .Zero(zero[0]), .AtTop(attop[0]),
    .Wrap(wrp[0]), .Sat(sat[0]), .Invalid(inv[0]));

  dekatron_step_counter #(.PULSE_CYCLES(3), .LIMIT_MODE(1), .OVF_MODE(0),
                          .TOP_VALUE(12'h255)) u_wrp (
    .Clk(clk), .Rst_n(rst_n), .Request(req[1]), .Op(op), .Steps(steps), .In(din),
    .Ready(rdy[1]), .Done(dn[1]), .Out(out[1]), .Zero(zero[1]), .AtTop(attop[1]),
    .Wrap(wrp[1]), .Sat(sat[1]), .Invalid(inv[1]));

  dekatron_step_counter #(.PULSE_CYCLES(1), .LIMIT_MODE(1), .OVF_MODE(1),
                          .TOP_VALUE(12'h255)) u_sat (
    .Clk(clk), .Rst_n(rst_n), .Request(req[2]), .Op(op), .Steps(steps), .In(din),
    .Ready(rdy[2]), .Done(dn[2]), .Out(out[2]), .Zero(zero[2]), .AtTop(attop[2]),
    .Wrap(wrp[2]), .Sat(sat[2]), .Invalid(inv[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one accept cycle; returns in cycle a+1.
  task automatic issue(input int u, input op_e o, input logic [7:0] s, input logic [11:0] v);
    req[u] = 1'b1; op = o; steps = s; din = v;
    tick();
    req[u] = 1'b0;
  endtask

  // Record cycles a+1..a+n into the trace arrays (index = offset from a).
  task automatic run_trace(input int u, input int n);
    for (int k = 1; k <= n; k++) begin
      out_tr[k] = out[u]; done_tr[k] = dn[u]; rdy_tr[k] = rdy[u];
      wrap_tr[k] = wrp[u]; sat_tr[k] = sat[u];
      tick();
    end
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; req = '0; op = 2'b00; steps = '0; din = '0;
    tick(2);
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_out", out[0], 12'h000);
    chk("rst_ready", rdy[0], 1);
    chk("rst_done", dn[0], 0);
    chk("rst_zero", zero[0], 1);
    chk("rst_flags", {wrp[0], sat[0], inv[0]}, 3'b000);

    // INC 1, P=10
    issue(0, OP_INC, 8'd1, 12'h000);
    run_trace(0, 12);
    chk("inc1_out_a1", out_tr[1], 12'h000);
    chk("inc1_out_a2", out_tr[2], 12'h001);
    chk("inc1_rdy_a1", rdy_tr[1], 0);
    chk("inc1_rdy_a10", rdy_tr[10], 0);
    chk("inc1_done_a10", done_tr[10], 0);
    chk("inc1_done_a11", done_tr[11], 1);
    chk("inc1_rdy_a11", rdy_tr[11], 1);

    // SET 199, INC 3 with two-digit carry
    issue(0, OP_SET, 8'd0, 12'h199);
    tick();
    chk("set199_out", out[0], 12'h199);
    chk("set199_done", dn[0], 1);
    chk("set199_rdy", rdy[0], 1);
    issue(0, OP_INC, 8'd3, 12'h000);
    run_trace(0, 32);
    chk("inc3_out_a2", out_tr[2], 12'h200);
    chk("inc3_out_a11", out_tr[11], 12'h200);
    chk("inc3_out_a12", out_tr[12], 12'h201);
    chk("inc3_out_a22", out_tr[22], 12'h202);
    chk("inc3_done_a31", done_tr[31], 1);
    nd = 0;
    for (int k = 1; k <= 32; k++) nd += done_tr[k];
    chk("inc3_done_cnt", nd, 1);

    // TOP=255, wrap, P=3
    issue(1, OP_SET, 8'd0, 12'h254);
    tick();
    chk("w_set254", out[1], 12'h254);
    issue(1, OP_INC, 8'd3, 12'h000);
    run_trace(1, 12);
    chk("w_inc_a2", out_tr[2], 12'h255);
    chk("w_inc_wrap_a4", wrap_tr[4], 0);
    chk("w_inc_a5", out_tr[5], 12'h000);
    chk("w_inc_wrap_a5", wrap_tr[5], 1);
    chk("w_inc_wrap_a6", wrap_tr[6], 0);
    chk("w_inc_a8", out_tr[8], 12'h001);
    chk("w_inc_done_a10", done_tr[10], 1);
    issue(1, OP_DEC, 8'd2, 12'h000);
    run_trace(1, 8);
    chk("w_dec_a2", out_tr[2], 12'h000);
    chk("w_dec_wrap_a2", wrap_tr[2], 0);
    chk("w_dec_a5", out_tr[5], 12'h255);
    chk("w_dec_wrap_a5", wrap_tr[5], 1);
    chk("w_dec_done_a7", done_tr[7], 1);
    chk("w_attop", attop[1], 1);

    // TOP=255, saturate, P=1
    issue(2, OP_SET, 8'd0, 12'h253);
    tick();
    chk("s_set253", out[2], 12'h253);
    issue(2, OP_INC, 8'd5, 12'h000);
    run_trace(2, 6);
    chk("s_a2", out_tr[2], 12'h254);
    chk("s_a3", out_tr[3], 12'h255);
    chk("s_sat_a3", sat_tr[3], 0);
    chk("s_done_a3", done_tr[3], 0);
    chk("s_a4", out_tr[4], 12'h255);
    chk("s_sat_a4", sat_tr[4], 1);
    chk("s_done_a4", done_tr[4], 1);
    chk("s_rdy_a4", rdy_tr[4], 1);
    chk("s_done_a5", done_tr[5], 0);

    // Rejected SETs and CLEAR
    issue(0, OP_SET, 8'd0, 12'h2A0);
    tick();
    chk("inv_nonbcd", inv[0], 1);
    chk("inv_nonbcd_out", out[0], 12'h202);
    chk("inv_nonbcd_done", dn[0], 1);
    issue(1, OP_SET, 8'd0, 12'h300);
    tick();
    chk("inv_above", inv[1], 1);
    chk("inv_above_out", out[1], 12'h255);
    chk("inv_above_done", dn[1], 1);
    issue(1, OP_CLEAR, 8'd0, 12'h000);
    tick();
    chk("clr_out", out[1], 12'h000);
    chk("clr_zero", zero[1], 1);
    chk("clr_inv", inv[1], 0);
    issue(1, OP_SET, 8'd0, 12'h255);
    tick();
    chk("set_eq_top", out[1], 12'h255);
    chk("set_eq_top_inv", inv[1], 0);

    // Busy pulse ignored, held request re-accepted when Ready returns
    issue(0, OP_CLEAR, 8'd0, 12'h000);
    tick();
    issue(0, OP_INC, 8'd2, 12'h000);
    for (int k = 1; k <= 24; k++) begin
      out_tr[k] = out[0]; done_tr[k] = dn[0];
      if (k == 5)  begin req[0] = 1'b1; op = OP_CLEAR; end
      if (k == 6)  req[0] = 1'b0;
      if (k == 15) begin req[0] = 1'b1; op = OP_SET; din = 12'h777; end
      if (k == 22) req[0] = 1'b0;
      tick();
    end
    chk("busy_a2", out_tr[2], 12'h001);
    chk("busy_a12", out_tr[12], 12'h002);
    chk("busy_a21", out_tr[21], 12'h002);
    chk("busy_done_a21", done_tr[21], 1);
    chk("busy_done_a22", done_tr[22], 0);
    chk("held_done_a23", done_tr[23], 1);
    chk("held_out_a23", out_tr[23], 12'h777);

    // Reset in the middle of a WAIT
    issue(0, OP_INC, 8'd5, 12'h000);
    tick(5);
    chk("pre_rst_rdy", rdy[0], 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", out[0], 12'h000);
    chk("mid_rst_rdy", rdy[0], 1);
    chk("mid_rst_done", dn[0], 0);
    tick(2);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      nd += dn[0];
      tick();
    end
    chk("post_rst_no_done", nd, 0);
    chk("post_rst_out", out[0], 12'h000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
